// File: rtl/rv_pkg.sv
// Shared RV32I decode constants: opcodes, funct fields, ALU ops, mux selects.
package rv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [3:0] ALU_ADD    = 4'h0;
  localparam logic [3:0] ALU_SUB    = 4'h1;
  localparam logic [3:0] ALU_AND    = 4'h2;
  localparam logic [3:0] ALU_OR     = 4'h3;
  localparam logic [3:0] ALU_XOR    = 4'h4;
  localparam logic [3:0] ALU_SLL    = 4'h5;
  localparam logic [3:0] ALU_SRL    = 4'h6;
  localparam logic [3:0] ALU_SRA    = 4'h7;
  localparam logic [3:0] ALU_SLT    = 4'h8;
  localparam logic [3:0] ALU_SLTU   = 4'h9;
  localparam logic [3:0] ALU_COPY_B = 4'hF;

  localparam logic [1:0] PC_SRC_PC4    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] MEM_TO_REG_ALU = 2'b00;
  localparam logic [1:0] MEM_TO_REG_MEM = 2'b01;
  localparam logic [1:0] MEM_TO_REG_PC4 = 2'b10;

  localparam logic [1:0] ALU_SRC_B_RS2 = 2'b00;
  localparam logic [1:0] ALU_SRC_B_IMM = 2'b01;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic [1:0] pc_src;
    logic       branch;
    logic       jump;
    logic       illegal;
    logic       muldiv;
    logic [2:0] muldiv_op;
  } ctrl_t;

  // SUB only exists for register-register ops; SRA/SRAI both use the alt funct7.
  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt,
                                            input logic is_reg);
    logic [3:0] op;
    unique case (f3)
      3'b000:  op = (alt && is_reg) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: selects I/S/B/U/J format by opcode and sign-extends.
import rv_pkg::*;

module imm_gen #(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (instr[6:0])
      OPC_OPIMM, OPC_LOAD, OPC_JALR:
        imm32 = {{20{instr[31]}}, instr[31:20]};
      OPC_STORE:
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OPC_BRANCH:
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm32 = {instr[31:12], 12'b0};
      OPC_JAL:
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:
        imm32 = '0;
    endcase
  end

  assign imm = imm32;

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage with registered ID/EX bundle, load-use stall and flush.
// Define RV32M_EN to decode M-extension ops instead of flagging them illegal.
import rv_pkg::*;

module decode_stage #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned LOAD_USE_STALL = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            if_valid_i,
  output logic            id_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            flush_i,
  output logic            ex_valid_o,
  input  logic            ex_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] imm_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic            reg_write_en_o,
  output logic [1:0]      mem_to_reg_o,
  output logic            mem_read_en_o,
  output logic            mem_write_en_o,
  output logic [1:0]      alu_src_b_o,
  output logic [3:0]      alu_op_o,
  output logic [1:0]      pc_src_o,
  output logic            branch_o,
  output logic            jump_o,
  output logic            illegal_o,
  output logic            muldiv_o,
  output logic [2:0]      muldiv_op_o
);

  localparam logic [2:0] StallInit = 3'(LOAD_USE_STALL - 1);

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  ctrl_t           ctrl, ctrl_d, ctrl_q;
  logic            uses_rs1, uses_rs2;
  logic [XLEN-1:0] imm, imm_d, imm_q, pc_d, pc_q;
  logic            valid_d, valid_q;
  logic [2:0]      stall_cnt_d, stall_cnt_q;
  logic [4:0]      stall_rd_d, stall_rd_q;
  logic            hazard, hit1, hit2, load_out, accept, leave;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (instr_i),
    .imm   (imm)
  );

  always_comb begin
    ctrl           = '0;
    ctrl.rs1       = instr_i[19:15];
    ctrl.rs2       = instr_i[24:20];
    ctrl.rd        = instr_i[11:7];
    ctrl.alu_op    = ALU_ADD;
    ctrl.mem_to_reg = MEM_TO_REG_ALU;
    ctrl.pc_src    = PC_SRC_PC4;
    ctrl.alu_src_b = ALU_SRC_B_RS2;
    uses_rs1       = 1'b0;
    uses_rs2       = 1'b0;
    case (opcode)
      OPC_OP: begin
        uses_rs1       = 1'b1;
        uses_rs2       = 1'b1;
        ctrl.reg_write = 1'b1;
        if (funct7 == F7_MULDIV) begin
`ifdef RV32M_EN
          ctrl.muldiv    = 1'b1;
          ctrl.muldiv_op = funct3;
`else
          ctrl.illegal   = 1'b1;
          ctrl.reg_write = 1'b0;
`endif
        end else begin
          ctrl.alu_op = alu_decode(funct3, funct7 == F7_ALT, 1'b1);
        end
      end
      OPC_OPIMM: begin
        uses_rs1       = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_b = ALU_SRC_B_IMM;
        ctrl.alu_op    = alu_decode(funct3, funct7 == F7_ALT, 1'b0);
      end
      OPC_LOAD: begin
        uses_rs1        = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = MEM_TO_REG_MEM;
        ctrl.alu_src_b  = ALU_SRC_B_IMM;
      end
      OPC_STORE: begin
        uses_rs1       = 1'b1;
        uses_rs2       = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_src_b = ALU_SRC_B_IMM;
      end
      OPC_BRANCH: begin
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
        ctrl.branch = 1'b1;
        ctrl.pc_src = PC_SRC_BRANCH;
        ctrl.alu_op = ALU_SUB;
      end
      OPC_JAL, OPC_JALR: begin
        uses_rs1        = (opcode == OPC_JALR);
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.pc_src     = PC_SRC_JUMP;
        ctrl.mem_to_reg = MEM_TO_REG_PC4;
        ctrl.alu_src_b  = ALU_SRC_B_IMM;
      end
      OPC_LUI, OPC_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_b = ALU_SRC_B_IMM;
        ctrl.alu_op    = (opcode == OPC_LUI) ? ALU_COPY_B : ALU_ADD;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

  // A source matches either the load sitting in the output reg or one still in its shadow.
  assign load_out = valid_q & ctrl_q.mem_read;
  assign hit1 = (ctrl.rs1 != 5'd0) & ((load_out & (ctrl_q.rd == ctrl.rs1)) |
                ((stall_cnt_q != 3'd0) & (stall_rd_q == ctrl.rs1)));
  assign hit2 = (ctrl.rs2 != 5'd0) & ((load_out & (ctrl_q.rd == ctrl.rs2)) |
                ((stall_cnt_q != 3'd0) & (stall_rd_q == ctrl.rs2)));
  assign hazard = (uses_rs1 & hit1) | (uses_rs2 & hit2);

  assign id_ready_o = ~flush_i & ~hazard & (~valid_q | ex_ready_i);
  assign accept     = if_valid_i & id_ready_o;
  assign leave      = valid_q & ex_ready_i;

  always_comb begin
    valid_d     = valid_q;
    ctrl_d      = ctrl_q;
    imm_d       = imm_q;
    pc_d        = pc_q;
    stall_cnt_d = stall_cnt_q;
    stall_rd_d  = stall_rd_q;
    if (flush_i) begin
      valid_d     = 1'b0;
      stall_cnt_d = 3'd0;
    end else begin
      if (leave && ctrl_q.mem_read) begin
        stall_cnt_d = StallInit;
        stall_rd_d  = ctrl_q.rd;
      end else if (stall_cnt_q != 3'd0) begin
        stall_cnt_d = stall_cnt_q - 3'd1;
      end
      if (accept) begin
        valid_d = 1'b1;
        ctrl_d  = ctrl;
        imm_d   = imm;
        pc_d    = pc_i;
      end else if (leave) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q     <= 1'b0;
      ctrl_q      <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      stall_cnt_q <= 3'd0;
      stall_rd_q  <= 5'd0;
    end else begin
      valid_q     <= valid_d;
      ctrl_q      <= ctrl_d;
      imm_q       <= imm_d;
      pc_q        <= pc_d;
      stall_cnt_q <= stall_cnt_d;
      stall_rd_q  <= stall_rd_d;
    end
  end

  assign ex_valid_o     = valid_q;
  assign pc_o           = pc_q;
  assign imm_o          = imm_q;
  assign rs1_o          = ctrl_q.rs1;
  assign rs2_o          = ctrl_q.rs2;
  assign rd_o           = ctrl_q.rd;
  assign reg_write_en_o = ctrl_q.reg_write;
  assign mem_to_reg_o   = ctrl_q.mem_to_reg;
  assign mem_read_en_o  = ctrl_q.mem_read;
  assign mem_write_en_o = ctrl_q.mem_write;
  assign alu_src_b_o    = ctrl_q.alu_src_b;
  assign alu_op_o       = ctrl_q.alu_op;
  assign pc_src_o       = ctrl_q.pc_src;
  assign branch_o       = ctrl_q.branch;
  assign jump_o         = ctrl_q.jump;
  assign illegal_o      = ctrl_q.illegal;
  assign muldiv_o       = ctrl_q.muldiv;
  assign muldiv_op_o    = ctrl_q.muldiv_op;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; expectations are hand-decoded RV32I fields.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid, id_ready, flush, ex_valid, ex_ready;
  logic [31:0] instr, pc, pc_out, imm;
  logic [4:0]  rs1, rs2, rd;
  logic        reg_write, mem_read, mem_write, branch, jump, illegal, muldiv;
  logic [1:0]  mem_to_reg, alu_src_b, pc_src;
  logic [3:0]  alu_op;
  logic [2:0]  muldiv_op;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .if_valid_i     (if_valid),
    .id_ready_o     (id_ready),
    .instr_i        (instr),
    .pc_i           (pc),
    .flush_i        (flush),
    .ex_valid_o     (ex_valid),
    .ex_ready_i     (ex_ready),
    .pc_o           (pc_out),
    .imm_o          (imm),
    .rs1_o          (rs1),
    .rs2_o          (rs2),
    .rd_o           (rd),
    .reg_write_en_o (reg_write),
    .mem_to_reg_o   (mem_to_reg),
    .mem_read_en_o  (mem_read),
    .mem_write_en_o (mem_write),
    .alu_src_b_o    (alu_src_b),
    .alu_op_o       (alu_op),
    .pc_src_o       (pc_src),
    .branch_o       (branch),
    .jump_o         (jump),
    .illegal_o      (illegal),
    .muldiv_o       (muldiv),
    .muldiv_op_o    (muldiv_op)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; if_valid = 1'b0; flush = 1'b0; ex_ready = 1'b0;
    instr = 32'h0; pc = 32'h0;
    #1;
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_imm", imm, 32'd0);
    chk("rst_ready", 32'(id_ready), 32'd1);
    #20 rst_n = 1'b1;
    step();

    // ADD x3,x1,x2
    instr = 32'h002081B3; pc = 32'h100; if_valid = 1'b1; ex_ready = 1'b1;
    #1 chk("add_ready", 32'(id_ready), 32'd1);
    step();
    chk("add_valid", 32'(ex_valid), 32'd1);
    chk("add_alu_op", 32'(alu_op), 32'd0);
    chk("add_rd", 32'(rd), 32'd3);
    chk("add_rs1", 32'(rs1), 32'd1);
    chk("add_rs2", 32'(rs2), 32'd2);
    chk("add_we", 32'(reg_write), 32'd1);
    chk("add_srcb", 32'(alu_src_b), 32'd0);
    chk("add_pc", pc_out, 32'h100);

    // LW x5,0(x1) followed by dependent ADD x6,x5,x5
    instr = 32'h0000A283; pc = 32'h104;
    step();
    chk("lw_valid", 32'(ex_valid), 32'd1);
    chk("lw_mrd", 32'(mem_read), 32'd1);
    chk("lw_m2r", 32'(mem_to_reg), 32'd1);
    chk("lw_rd", 32'(rd), 32'd5);
    chk("lw_srcb", 32'(alu_src_b), 32'd1);
    instr = 32'h00528333; pc = 32'h108;
    #1 chk("luse_ready", 32'(id_ready), 32'd0);
    step();
    chk("bubble_valid", 32'(ex_valid), 32'd0);
    chk("bubble_ready", 32'(id_ready), 32'd1);
    step();
    chk("dep_valid", 32'(ex_valid), 32'd1);
    chk("dep_rd", 32'(rd), 32'd6);
    chk("dep_pc", pc_out, 32'h108);

    // Backpressure: ADDI x7,x0,-1 waits behind a stalled bundle
    ex_ready = 1'b0; instr = 32'hFFF00393; pc = 32'h10C;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready", 32'(id_ready), 32'd0);
      step();
      chk("bp_valid", 32'(ex_valid), 32'd1);
      chk("bp_rd", 32'(rd), 32'd6);
      chk("bp_pc", pc_out, 32'h108);
    end
    ex_ready = 1'b1;
    step();
    chk("addi_rd", 32'(rd), 32'd7);
    chk("addi_imm", imm, 32'hFFFFFFFF);
    chk("addi_srcb", 32'(alu_src_b), 32'd1);
    chk("addi_alu", 32'(alu_op), 32'd0);

    // Flush with a valid bundle and a valid incoming instr
    ex_ready = 1'b0; flush = 1'b1; instr = 32'h002081B3; pc = 32'h200;
    #1 chk("flush_ready", 32'(id_ready), 32'd0);
    step();
    chk("flush_valid", 32'(ex_valid), 32'd0);
    flush = 1'b0; if_valid = 1'b0;
    step();
    chk("flush_drop", 32'(ex_valid), 32'd0);

    // MUL x3,x1,x2
    if_valid = 1'b1; ex_ready = 1'b1; instr = 32'h022081B3; pc = 32'h300;
    step();
    chk("mul_valid", 32'(ex_valid), 32'd1);
`ifdef RV32M_EN
    chk("mul_md", 32'(muldiv), 32'd1);
    chk("mul_op", 32'(muldiv_op), 32'd0);
    chk("mul_ill", 32'(illegal), 32'd0);
    chk("mul_we", 32'(reg_write), 32'd1);
`else
    chk("mul_md", 32'(muldiv), 32'd0);
    chk("mul_ill", 32'(illegal), 32'd1);
    chk("mul_we", 32'(reg_write), 32'd0);
`endif

    // BEQ x1,x2,-4
    instr = 32'hFE208EE3; pc = 32'h304;
    step();
    chk("beq_imm", imm, 32'hFFFFFFFC);
    chk("beq_br", 32'(branch), 32'd1);
    chk("beq_pcsrc", 32'(pc_src), 32'd1);
    chk("beq_alu", 32'(alu_op), 32'd1);
    chk("beq_we", 32'(reg_write), 32'd0);

    // LUI x1,0x12345
    instr = 32'h123450B7; pc = 32'h308;
    step();
    chk("lui_imm", imm, 32'h12345000);
    chk("lui_alu", 32'(alu_op), 32'hF);

    // JAL x1,+8
    instr = 32'h008000EF; pc = 32'h30C;
    step();
    chk("jal_imm", imm, 32'h8);
    chk("jal_m2r", 32'(mem_to_reg), 32'd2);
    chk("jal_pcsrc", 32'(pc_src), 32'd2);
    chk("jal_jump", 32'(jump), 32'd1);
    chk("jal_rd", 32'(rd), 32'd1);

    // Unknown opcode still passes through as a valid bundle
    instr = 32'hFFFFFFFF; pc = 32'h310;
    step();
    chk("ill_valid", 32'(ex_valid), 32'd1);
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_we", 32'(reg_write), 32'd0);
    chk("ill_mrd", 32'(mem_read), 32'd0);

    // Async reset while a bundle is held
    if_valid = 1'b0; ex_ready = 1'b0; instr = 32'h0;
    #3 rst_n = 1'b0;
    #1 chk("arst_valid", 32'(ex_valid), 32'd0);
    chk("arst_ill", 32'(illegal), 32'd0);
    #1 rst_n = 1'b1;
    step();
    chk("arst_ready", 32'(id_ready), 32'd1);
    chk("arst_valid2", 32'(ex_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
